serial_pattern_tx: RTL

Serial bit-pattern transmitter: accepts a parallel word over a valid/ready handshake and drives it MSB-first, one bit per clock, on a single serial line `x`, framed by `x_valid`. It is the driving end of the serial `x` input used by the sequence-detector FSMs in this module set, so a detector can be fed from registers instead of hand-written stimulus. Built as a Moore FSM with a shift register and a bit/gap down-counter.

---
 rtl/serial_pattern_pkg.sv | 14 +
 rtl/serial_pattern_tx_cnt.sv | 40 ++++
 rtl/serial_pattern_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared state encodings for the serial pattern transmitter
// and the sequence-detector FSMs fed from it.
package serial_pattern_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    ILL  = 2'b11
  } sp_state_e;

endpackage

// File: rtl/serial_pattern_tx_cnt.sv
// Loadable down-counter shared by the bit count and gap count.
// Load wins over decrement; decrement saturates at zero.
module load_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, step down, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: parallel word in over valid/ready,
// MSB-first serial out on x framed by x_valid, optional idle gap.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int GAP_CYCLES = 1,
  localparam int LW         = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [LW-1:0]      in_len,
  output logic               in_ready,
  output logic               x,
  output logic               x_valid,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = (LW > GW) ? LW : GW;

  sp_state_e        state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic [CW-1:0]    cnt_val;
  logic             cnt_dec;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             cnt_one;
  logic [LW-1:0]    len_eff;

  load_down_counter #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign cnt_one = (cnt == CW'(1));

  // Out-of-range lengths (0 or above WIDTH) send the full word.
  always_comb begin
    len_eff = in_len;
    if ((in_len == '0) || (in_len > LW'(WIDTH))) begin
      len_eff = LW'(WIDTH);
    end
  end

  // Next state, shifter and counter control.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = SEND;
          sh_d     = in_data << (LW'(WIDTH) - len_eff);
          cnt_load = 1'b1;
          cnt_val  = CW'(len_eff);
        end
      end
      SEND: begin
        sh_d = sh_q << 1;
        if (cnt_one || cnt_zero) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            cnt_load = 1'b1;
            cnt_val  = CW'(GAP_CYCLES);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_one || cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered serial outputs follow the next state.
  always_comb begin
    x_d    = (state_d == SEND) & sh_d[WIDTH-1];
    xv_d   = (state_d == SEND);
    done_d = (state_q == SEND) && (state_d != SEND);
  end

  // State, shifter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign x        = x_q;
  assign x_valid  = xv_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule
